// File: rtl/mem_pkg.sv
// Shared encodings for the memory access stage: opcodes, access sizes, FSM states, fault causes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    // Major opcodes that select a data-memory access
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;

    // funct3 access size / sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access state machine
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Fault cause codes reported to the trap logic
    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN    = 2'b01;
    localparam logic [1:0] CAUSE_BUS_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b11;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_I_LOAD) || (op == OP_S);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: enables and store replication from size/offset, load extract/extend, fault flags.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int NBYTES = XLEN / 8,
    localparam int OFFW   = $clog2(NBYTES)
) (
    input  logic [2:0]        funct3,
    input  logic              is_store,
    input  logic [OFFW-1:0]   offset,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_data,
    output logic [NBYTES-1:0] byte_sel,
    output logic [XLEN-1:0]   store_lanes,
    output logic [XLEN-1:0]   load_value,
    output logic              misaligned,
    output logic              illegal
);

    logic [1:0]      size_log;
    logic            sx;
    int              nb;
    int              off;
    logic [XLEN-1:0] shifted;

    // Decode access size; unsigned variants only exist for loads, 64-bit sizes only on RV64
    always_comb begin
        illegal  = 1'b1;
        size_log = 2'd0;
        case (funct3)
            F3_B:  begin illegal = 1'b0;     size_log = 2'd0; end
            F3_H:  begin illegal = 1'b0;     size_log = 2'd1; end
            F3_W:  begin illegal = 1'b0;     size_log = 2'd2; end
            F3_D:  begin illegal = (XLEN != 64); size_log = 2'd3; end
            F3_BU: begin illegal = is_store; size_log = 2'd0; end
            F3_HU: begin illegal = is_store; size_log = 2'd1; end
            F3_WU: begin illegal = is_store || (XLEN != 64); size_log = 2'd2; end
            default: begin illegal = 1'b1;   size_log = 2'd0; end
        endcase
    end

    // Lane enables, store replication and alignment check
    always_comb begin
        nb         = 1 << size_log;
        off        = int'(offset);
        misaligned = !illegal && ((off & (nb - 1)) != 0);
        byte_sel   = '0;
        store_lanes = '0;
        for (int i = 0; i < NBYTES; i++) begin
            byte_sel[i]          = (i >= off) && (i < off + nb);
            store_lanes[8*i +: 8] = store_data[8*(i & (nb - 1)) +: 8];
        end
    end

    // Load lane extract, then sign or zero extension (funct3[2] marks unsigned)
    always_comb begin
        shifted    = load_data >> {offset, 3'b000};
        sx         = !funct3[2];
        load_value = shifted;
        case (size_log)
            2'd0: begin
                load_value       = {XLEN{sx & shifted[7]}};
                load_value[7:0]  = shifted[7:0];
            end
            2'd1: begin
                load_value       = {XLEN{sx & shifted[15]}};
                load_value[15:0] = shifted[15:0];
            end
            2'd2: begin
                load_value       = {XLEN{sx & shifted[31]}};
                load_value[31:0] = shifted[31:0];
            end
            default: load_value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: loads/stores over a busy/done RAM handshake with fault detection and watchdog.
// Latency: non-memory ops 0 cycles; accesses answer in RESP after IDLE+REQ (+1 per busy/wait cycle).
// Backpressure: stall_req_o holds upstream in IDLE (mem op), REQ and WAIT; ram_busy holds the request.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int TIMEOUT = 255,
    localparam int NBYTES  = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        aluop_i,
    input  logic [2:0]        funct3,
    input  logic              rd_we_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [XLEN-1:0]   rd_data_i,
    input  logic [XLEN-1:0]   s_data_i,
    input  logic [XLEN-1:0]   ram_addr_i,
    output logic              rd_we,
    output logic [4:0]        rd_addr,
    output logic [XLEN-1:0]   rd_data,
    output logic              ram_ce,
    output logic              ram_we_o,
    output logic [XLEN-1:0]   ram_addr_o,
    output logic [XLEN-1:0]   ram_data_o,
    output logic [NBYTES-1:0] ram_byte_sel_o,
    input  logic              ram_busy,
    input  logic              ram_done,
    input  logic [XLEN-1:0]   ram_data_i,
    output logic              stall_req_o,
    output logic              fault_o,
    output logic [1:0]        fault_cause_o,
    output logic              fault_is_store_o,
    output logic [XLEN-1:0]   fault_addr_o
);

    localparam int OFFW = $clog2(NBYTES);
    localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state, state_nxt;
    logic              is_store_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   sdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              rd_we_q;
    logic [4:0]        rd_addr_q;
    logic [XLEN-1:0]   rd_data_q;
    logic [1:0]        cause_q;
    logic [CW-1:0]     cnt;

    logic              mem_op;
    logic              in_idle;
    logic              bus_state;
    logic              accept_done;
    logic              timeout;
    logic [2:0]        la_f3;
    logic              la_store;
    logic [OFFW-1:0]   la_off;
    logic [NBYTES-1:0] la_bsel;
    logic [XLEN-1:0]   la_lanes;
    logic [XLEN-1:0]   la_load;
    logic              la_misaligned;
    logic              la_illegal;

    assign mem_op    = is_mem_op(aluop_i);
    assign in_idle   = (state == ST_IDLE);
    assign bus_state = (state == ST_REQ) || (state == ST_WAIT);

    // In IDLE the aligner checks the live instruction; afterwards it works from the latched access
    assign la_f3    = in_idle ? funct3 : f3_q;
    assign la_store = in_idle ? (aluop_i == OP_S) : is_store_q;
    assign la_off   = in_idle ? ram_addr_i[OFFW-1:0] : addr_q[OFFW-1:0];

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .funct3      (la_f3),
        .is_store    (la_store),
        .offset      (la_off),
        .store_data  (sdata_q),
        .load_data   (rdata_q),
        .byte_sel    (la_bsel),
        .store_lanes (la_lanes),
        .load_value  (la_load),
        .misaligned  (la_misaligned),
        .illegal     (la_illegal)
    );

    assign accept_done = ((state == ST_REQ) && !ram_busy && ram_done) ||
                         ((state == ST_WAIT) && ram_done);
    assign timeout     = (TIMEOUT != 0) && bus_state && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a completing transfer wins over a simultaneous watchdog expiry
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_op) state_nxt = (la_illegal || la_misaligned) ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                if (!ram_busy && ram_done) state_nxt = ST_RESP;
                else if (timeout)          state_nxt = ST_RESP;
                else if (!ram_busy)        state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (ram_done || timeout) state_nxt = ST_RESP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture registers: access fields in IDLE, read data or timeout cause during the bus phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            rdata_q    <= '0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            cause_q    <= CAUSE_NONE;
        end else if (in_idle && mem_op) begin
            is_store_q <= (aluop_i == OP_S);
            f3_q       <= funct3;
            addr_q     <= ram_addr_i;
            sdata_q    <= s_data_i;
            rd_we_q    <= rd_we_i;
            rd_addr_q  <= rd_addr_i;
            rd_data_q  <= rd_data_i;
            cause_q    <= la_illegal    ? CAUSE_ILLEGAL  :
                          la_misaligned ? CAUSE_MISALIGN : CAUSE_NONE;
        end else if (accept_done) begin
            rdata_q    <= ram_data_i;
        end else if (timeout) begin
            cause_q    <= CAUSE_BUS_TIMEOUT;
        end
    end

    // Watchdog: zero in IDLE so the first REQ cycle counts as 0, then counts through REQ/WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cnt <= '0;
        else if (in_idle)   cnt <= '0;
        else if (bus_state) cnt <= cnt + 1'b1;
    end

    // Outputs; everything is forced low while reset is held, including the passthrough path
    always_comb begin
        rd_we            = 1'b0;
        rd_addr          = '0;
        rd_data          = '0;
        ram_ce           = 1'b0;
        ram_we_o         = 1'b0;
        ram_addr_o       = '0;
        ram_data_o       = '0;
        ram_byte_sel_o   = '0;
        stall_req_o      = 1'b0;
        fault_o          = 1'b0;
        fault_cause_o    = CAUSE_NONE;
        fault_is_store_o = 1'b0;
        fault_addr_o     = '0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        stall_req_o = 1'b1;
                    end else begin
                        rd_we   = rd_we_i;
                        rd_addr = rd_addr_i;
                        rd_data = rd_data_i;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    stall_req_o    = 1'b1;
                    ram_ce         = 1'b1;
                    ram_we_o       = is_store_q;
                    ram_addr_o     = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
                    ram_byte_sel_o = la_bsel;
                    ram_data_o     = is_store_q ? la_lanes : '0;
                end
                default: begin
                    if (cause_q != CAUSE_NONE) begin
                        fault_o          = 1'b1;
                        fault_cause_o    = cause_q;
                        fault_is_store_o = is_store_q;
                        fault_addr_o     = addr_q;
                    end else if (is_store_q) begin
                        rd_we   = rd_we_q;
                        rd_addr = rd_addr_q;
                        rd_data = rd_data_q;
                    end else begin
                        rd_we   = rd_we_q;
                        rd_addr = rd_addr_q;
                        rd_data = la_load;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: RV32 (TIMEOUT=8) and RV64 instances, one active at a time.
// Latency: n/a.
// Backpressure: RAM model drives busy/done from per-transaction cycle counts.
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct {
        int          id;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [63:0] rd_data;
        logic        fault;
        logic [1:0]  cause;
        logic [63:0] faddr;
        logic        fstore;
        int          stalls;
        int          ce;
        logic [63:0] ram_addr;
        logic [7:0]  bsel;
        logic        we;
        logic [63:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic [6:0]  aluop = 7'h13;
    logic [2:0]  f3 = 3'b000;
    logic [63:0] addr = '0;
    logic [63:0] sdata = '0;
    logic        rwe = 1'b0;
    logic [4:0]  raddr = '0;
    logic [63:0] rdat = '0;
    logic [63:0] rram = '0;
    int          busy_n = 0;
    int          wait_n = 0;
    logic        nodone = 1'b0;
    logic        active = 1'b0;
    int          ram_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    // RV32 instance
    logic        rd_we32, ram_ce32, ram_we32, stall32, fault32, fstore32;
    logic [4:0]  rd_addr32;
    logic [31:0] rd_data32, ram_addr32, ram_wdata32, faddr32;
    logic [3:0]  bsel32;
    logic [1:0]  cause32;
    // RV64 instance
    logic        rd_we64, ram_ce64, ram_we64, stall64, fault64, fstore64;
    logic [4:0]  rd_addr64;
    logic [63:0] rd_data64, ram_addr64, ram_wdata64, faddr64;
    logic [7:0]  bsel64;
    logic [1:0]  cause64;

    logic        ram_busy, ram_done;
    logic [6:0]  aluop32, aluop64;

    assign aluop32 = sel64 ? 7'h13 : aluop;
    assign aluop64 = sel64 ? aluop : 7'h13;

    // Observed outputs of whichever instance is selected
    logic        mon_rd_we, mon_ce, mon_we, mon_stall, mon_fault, mon_fstore;
    logic [4:0]  mon_rd_addr;
    logic [63:0] mon_rd_data, mon_ram_addr, mon_wdata, mon_faddr;
    logic [7:0]  mon_bsel;
    logic [1:0]  mon_cause;

    assign mon_rd_we    = sel64 ? rd_we64    : rd_we32;
    assign mon_rd_addr  = sel64 ? rd_addr64  : rd_addr32;
    assign mon_rd_data  = sel64 ? rd_data64  : {32'b0, rd_data32};
    assign mon_ce       = sel64 ? ram_ce64   : ram_ce32;
    assign mon_we       = sel64 ? ram_we64   : ram_we32;
    assign mon_ram_addr = sel64 ? ram_addr64 : {32'b0, ram_addr32};
    assign mon_wdata    = sel64 ? ram_wdata64 : {32'b0, ram_wdata32};
    assign mon_bsel     = sel64 ? bsel64     : {4'b0, bsel32};
    assign mon_stall    = sel64 ? stall64    : stall32;
    assign mon_fault    = sel64 ? fault64    : fault32;
    assign mon_cause    = sel64 ? cause64    : cause32;
    assign mon_fstore   = sel64 ? fstore64   : fstore32;
    assign mon_faddr    = sel64 ? faddr64    : {32'b0, faddr32};

    // RAM model: busy for busy_n cycles of ram_ce, done wait_n cycles after acceptance
    assign ram_busy = mon_ce && (ram_cnt < busy_n);
    assign ram_done = mon_ce && !nodone && (ram_cnt >= busy_n + wait_n);
    always @(posedge clk) ram_cnt <= mon_ce ? ram_cnt + 1 : 0;

    mem_access_unit #(.XLEN(32), .TIMEOUT(8)) dut32 (
        .clk(clk), .rst(rst), .aluop_i(aluop32), .funct3(f3),
        .rd_we_i(rwe), .rd_addr_i(raddr), .rd_data_i(rdat[31:0]),
        .s_data_i(sdata[31:0]), .ram_addr_i(addr[31:0]),
        .rd_we(rd_we32), .rd_addr(rd_addr32), .rd_data(rd_data32),
        .ram_ce(ram_ce32), .ram_we_o(ram_we32), .ram_addr_o(ram_addr32),
        .ram_data_o(ram_wdata32), .ram_byte_sel_o(bsel32),
        .ram_busy(ram_busy), .ram_done(ram_done), .ram_data_i(rram[31:0]),
        .stall_req_o(stall32), .fault_o(fault32), .fault_cause_o(cause32),
        .fault_is_store_o(fstore32), .fault_addr_o(faddr32)
    );

    mem_access_unit #(.XLEN(64), .TIMEOUT(255)) dut64 (
        .clk(clk), .rst(rst), .aluop_i(aluop64), .funct3(f3),
        .rd_we_i(rwe), .rd_addr_i(raddr), .rd_data_i(rdat),
        .s_data_i(sdata), .ram_addr_i(addr),
        .rd_we(rd_we64), .rd_addr(rd_addr64), .rd_data(rd_data64),
        .ram_ce(ram_ce64), .ram_we_o(ram_we64), .ram_addr_o(ram_addr64),
        .ram_data_o(ram_wdata64), .ram_byte_sel_o(bsel64),
        .ram_busy(ram_busy), .ram_done(ram_done), .ram_data_i(rram),
        .stall_req_o(stall64), .fault_o(fault64), .fault_cause_o(cause64),
        .fault_is_store_o(fstore64), .fault_addr_o(faddr64)
    );

    task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL id=%0d %s: got 0x%0h expected 0x%0h", id, nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input logic rwe_e, input logic [4:0] ra, input logic [63:0] rd,
                                input logic [1:0] cause, input logic [63:0] fa, input logic fst,
                                input int stalls, input int ce, input logic [63:0] ma,
                                input logic [7:0] bs, input logic we, input logic [63:0] wd);
        exp_t e;
        e.id = id; e.rd_we = rwe_e; e.rd_addr = ra; e.rd_data = rd;
        e.fault = (cause != 2'b00); e.cause = cause; e.faddr = fa; e.fstore = fst;
        e.stalls = stalls; e.ce = ce; e.ram_addr = ma; e.bsel = bs; e.we = we; e.wdata = wd;
        return e;
    endfunction

    // Monitor: counts stall and ram_ce cycles of the active instruction, checks at its response
    int          stall_cnt = 0;
    int          ce_cnt = 0;
    logic [63:0] seen_addr, seen_wdata;
    logic [7:0]  seen_bsel;
    logic        seen_we;
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
            ce_cnt    = 0;
        end else if (!active) begin
            chk(0, "idle_fault_o", {63'b0, mon_fault}, 64'd0);
        end else begin
            if (mon_ce) begin
                ce_cnt++;
                seen_addr  = mon_ram_addr;
                seen_wdata = mon_wdata;
                seen_bsel  = mon_bsel;
                seen_we    = mon_we;
            end
            if (mon_stall) begin
                stall_cnt++;
            end else if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_response: got response with no expectation queued");
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk(e.id, "stall_cycles", 64'(stall_cnt), 64'(e.stalls));
                chk(e.id, "ram_ce_cycles", 64'(ce_cnt), 64'(e.ce));
                chk(e.id, "fault_o", {63'b0, mon_fault}, {63'b0, e.fault});
                if (e.fault) begin
                    chk(e.id, "fault_cause", {62'b0, mon_cause}, {62'b0, e.cause});
                    chk(e.id, "fault_addr", mon_faddr, e.faddr);
                    chk(e.id, "fault_is_store", {63'b0, mon_fstore}, {63'b0, e.fstore});
                    chk(e.id, "rd_we_on_fault", {63'b0, mon_rd_we}, 64'd0);
                end else begin
                    chk(e.id, "rd_we", {63'b0, mon_rd_we}, {63'b0, e.rd_we});
                    chk(e.id, "rd_addr", {59'b0, mon_rd_addr}, {59'b0, e.rd_addr});
                    chk(e.id, "rd_data", mon_rd_data, e.rd_data);
                end
                if (e.ce > 0) begin
                    chk(e.id, "ram_addr", seen_addr, e.ram_addr);
                    chk(e.id, "byte_sel", {56'b0, seen_bsel}, {56'b0, e.bsel});
                    chk(e.id, "ram_we", {63'b0, seen_we}, {63'b0, e.we});
                    if (e.we) chk(e.id, "ram_wdata", seen_wdata, e.wdata);
                end
            end
            if (!mon_stall) begin
                stall_cnt = 0;
                ce_cnt    = 0;
            end
        end
    end

    task automatic issue(input bit is64, input logic [6:0] op, input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] sd, input logic we_i, input logic [4:0] ra, input logic [63:0] rd,
                         input int bn, input int wn, input logic nd, input logic [63:0] rr, input exp_t e);
        bit ok;
        @(posedge clk); #1;
        sel64 = is64; aluop = op; f3 = fn; addr = a; sdata = sd;
        rwe = we_i; raddr = ra; rdat = rd;
        busy_n = bn; wait_n = wn; nodone = nd; rram = rr;
        expq.push_back(e);
        active = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!mon_stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL id=%0d response_timeout: stall still high after 60 cycles, required release", e.id);
        end
        @(posedge clk); #1;
        active = 1'b0;
        aluop  = 7'h13;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        // Reset state with a live ALU op on the inputs: outputs must still be zero
        aluop = 7'h33; rwe = 1'b1; raddr = 5'd9; rdat = 64'hFFFF_FFFF_FFFF_FFFF;
        #12;
        chk(0, "reset_rd_we",   {63'b0, mon_rd_we}, 64'd0);
        chk(0, "reset_rd_addr", {59'b0, mon_rd_addr}, 64'd0);
        chk(0, "reset_rd_data", mon_rd_data, 64'd0);
        chk(0, "reset_stall",   {63'b0, mon_stall}, 64'd0);
        chk(0, "reset_ram_ce",  {63'b0, mon_ce}, 64'd0);
        #10;
        rst = 1'b0; aluop = 7'h13; rwe = 1'b0; raddr = '0; rdat = '0;

        // RV32 vectors
        issue(0, OP_I_LOAD, F3_B, 64'h1003, 64'h0, 1, 5'd5, 64'h0, 0, 0, 0, 64'h80FF_1234,
              mk(1, 1, 5'd5, 64'hFFFF_FF80, 2'b00, 0, 0, 2, 1, 64'h1000, 8'b1000, 0, 0));
        issue(0, OP_S, F3_H, 64'h2002, 64'h1234_ABCD, 0, 5'd0, 64'h2002, 3, 0, 0, 64'h0,
              mk(2, 0, 5'd0, 64'h2002, 2'b00, 0, 0, 5, 4, 64'h2000, 8'b1100, 1, 64'hABCD_ABCD));
        issue(0, OP_I_LOAD, F3_W, 64'h0006, 64'h0, 1, 5'd3, 64'h0, 0, 0, 0, 64'h0,
              mk(3, 0, 5'd0, 64'h0, 2'b01, 64'h6, 0, 1, 0, 0, 0, 0, 0));
        issue(0, OP_I_LOAD, F3_H, 64'h1000, 64'h0, 1, 5'd6, 64'h0, 1, 2, 0, 64'h1234_8765,
              mk(4, 1, 5'd6, 64'hFFFF_8765, 2'b00, 0, 0, 5, 4, 64'h1000, 8'b0011, 0, 0));
        issue(0, OP_I_LOAD, F3_HU, 64'h1002, 64'h0, 1, 5'd7, 64'h0, 0, 0, 0, 64'h8001_7FFF,
              mk(5, 1, 5'd7, 64'h0000_8001, 2'b00, 0, 0, 2, 1, 64'h1000, 8'b1100, 0, 0));
        issue(0, OP_S, F3_B, 64'h3001, 64'hFFFF_FF5A, 0, 5'd0, 64'h0, 0, 0, 0, 64'h0,
              mk(6, 0, 5'd0, 64'h0, 2'b00, 0, 0, 2, 1, 64'h3000, 8'b0010, 1, 64'h5A5A_5A5A));
        issue(0, OP_S, F3_W, 64'h3004, 64'hDEAD_BEEF, 0, 5'd0, 64'h0, 0, 1, 0, 64'h0,
              mk(7, 0, 5'd0, 64'h0, 2'b00, 0, 0, 3, 2, 64'h3004, 8'b1111, 1, 64'hDEAD_BEEF));
        issue(0, OP_S, F3_H, 64'h2001, 64'h1111, 0, 5'd0, 64'h0, 0, 0, 0, 64'h0,
              mk(8, 0, 5'd0, 64'h0, 2'b01, 64'h2001, 1, 1, 0, 0, 0, 0, 0));
        issue(0, OP_I_LOAD, F3_D, 64'h0010, 64'h0, 1, 5'd2, 64'h0, 0, 0, 0, 64'h0,
              mk(9, 0, 5'd0, 64'h0, 2'b11, 64'h10, 0, 1, 0, 0, 0, 0, 0));
        issue(0, OP_I_LOAD, F3_W, 64'h5000, 64'h0, 1, 5'd4, 64'h0, 0, 0, 1, 64'h0,
              mk(10, 0, 5'd0, 64'h0, 2'b10, 64'h5000, 0, 9, 8, 64'h5000, 8'b1111, 0, 0));
        issue(0, 7'h33, F3_B, 64'h0, 64'h0, 1, 5'd7, 64'hCAFE_F00D, 0, 0, 0, 64'h0,
              mk(11, 1, 5'd7, 64'hCAFE_F00D, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        // RV64 vectors
        issue(1, OP_I_LOAD, F3_WU, 64'h1004, 64'h0, 1, 5'd8, 64'h0, 0, 0, 0, 64'hF000_0001_0000_0002,
              mk(12, 1, 5'd8, 64'h0000_0000_F000_0001, 2'b00, 0, 0, 2, 1, 64'h1000, 8'hF0, 0, 0));
        issue(1, OP_I_LOAD, F3_W, 64'h1004, 64'h0, 1, 5'd9, 64'h0, 0, 0, 0, 64'hF000_0001_0000_0002,
              mk(13, 1, 5'd9, 64'hFFFF_FFFF_F000_0001, 2'b00, 0, 0, 2, 1, 64'h1000, 8'hF0, 0, 0));
        issue(1, OP_I_LOAD, F3_D, 64'h2008, 64'h0, 1, 5'd10, 64'h0, 0, 0, 0, 64'h1122_3344_5566_7788,
              mk(14, 1, 5'd10, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 2, 1, 64'h2008, 8'hFF, 0, 0));
        issue(1, OP_S, F3_H, 64'h200A, 64'hABCD, 0, 5'd0, 64'h0, 0, 0, 0, 64'h0,
              mk(15, 0, 5'd0, 64'h0, 2'b00, 0, 0, 2, 1, 64'h2008, 8'h0C, 1, 64'hABCD_ABCD_ABCD_ABCD));
        issue(1, 7'h13, F3_B, 64'h0, 64'h0, 1, 5'd11, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 64'h0,
              mk(16, 1, 5'd11, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset asserted while the RV32 instance waits on a RAM that never answers
        @(posedge clk); #1;
        sel64 = 1'b0; aluop = OP_I_LOAD; f3 = F3_W; addr = 64'h4000;
        rwe = 1'b1; raddr = 5'd9; rdat = 64'h55; busy_n = 0; wait_n = 0; nodone = 1'b1;
        active = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk(20, "wait_ram_ce_before_reset", {63'b0, mon_ce}, 64'd1);
        rst = 1'b1;
        #1;
        active = 1'b0; aluop = 7'h13;
        chk(20, "midreset_ram_ce",  {63'b0, mon_ce}, 64'd0);
        chk(20, "midreset_stall",   {63'b0, mon_stall}, 64'd0);
        chk(20, "midreset_rd_we",   {63'b0, mon_rd_we}, 64'd0);
        chk(20, "midreset_rd_addr", {59'b0, mon_rd_addr}, 64'd0);
        chk(20, "midreset_rd_data", mon_rd_data, 64'd0);
        chk(20, "midreset_fault",   {63'b0, mon_fault}, 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0; nodone = 1'b0;
        issue(0, 7'h33, F3_B, 64'h0, 64'h0, 1, 5'd12, 64'h0BAD_F00D, 0, 0, 0, 64'h0,
              mk(17, 1, 5'd12, 64'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        chk(0, "expect_queue_drained", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
